// File: rtl/shift_pkg.sv
// Shared constants for the ALU shift datapath: operand width and the
// encodings of the direction and arithmetic/logical select bits.
package shift_pkg;
  localparam int   DATA_W      = 32;
  localparam logic DIR_LEFT    = 1'b1;
  localparam logic DIR_RIGHT   = 1'b0;
  localparam logic SHIFT_ARITH = 1'b1;
  localparam logic SHIFT_LOGIC = 1'b0;
endpackage

// File: rtl/barrel_shift_stage.sv
// One mux level of the right-shift network. When enabled, it shifts right by
// a fixed distance DIST and fills the vacated MSBs with the fill bit.
module barrel_shift_stage #(
  parameter int DATA_W = 32,
  parameter int DIST   = 1
) (
  input  logic [DATA_W-1:0] data_in,
  input  logic              fill,
  input  logic              en,
  output logic [DATA_W-1:0] data_out
);

  always_comb begin
    data_out = data_in;
    if (en) data_out = {{DIST{fill}}, data_in[DATA_W-1:DIST]};
  end

endmodule

// File: rtl/barrel_shifter.sv
// 32-bit bidirectional barrel shifter with a registered result. Left shifts
// reuse the right-shift network by bit-reversing the operand and the result.
module barrel_shifter
  import shift_pkg::*;
#(
  parameter int DATA_W  = shift_pkg::DATA_W,
  parameter int SHAMT_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [DATA_W-1:0]  in,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic               dir,
  input  logic               aorl,
  input  logic               in_valid,
  output logic [DATA_W-1:0]  out,
  output logic               out_valid
);

  localparam int STAGES = $clog2(DATA_W);

  function automatic logic [DATA_W-1:0] bit_reverse(input logic [DATA_W-1:0] v);
    logic [DATA_W-1:0] r;
    for (int i = 0; i < DATA_W; i++) r[i] = v[DATA_W-1-i];
    return r;
  endfunction

  function automatic logic [DATA_W-1:0] saturate(input logic [DATA_W-1:0] v,
                                                 input logic sat,
                                                 input logic fill_bit);
    return sat ? {DATA_W{fill_bit}} : v;
  endfunction

  logic                     fill;
  logic                     sat;
  logic [DATA_W-1:0]        net [STAGES+1];
  logic [DATA_W-1:0]        result;

  // Only arithmetic right shifts replicate the sign bit; left fill must be 0.
  assign fill   = (dir == DIR_RIGHT) && (aorl == SHIFT_ARITH) && in[DATA_W-1];
  assign sat    = |shamt[SHAMT_W-1:STAGES];
  assign net[0] = (dir == DIR_LEFT) ? bit_reverse(in) : in;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    barrel_shift_stage #(
      .DATA_W (DATA_W),
      .DIST   (2 ** k)
    ) u_stage (
      .data_in  (net[k]),
      .fill     (fill),
      .en       (shamt[k]),
      .data_out (net[k+1])
    );
  end

  assign result = saturate((dir == DIR_LEFT) ? bit_reverse(net[STAGES]) : net[STAGES],
                           sat, fill);

  // Output register stage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out       <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) out <= result;
    end
  end

endmodule

// File: tb/tb_barrel_shifter.sv
// Bench for barrel_shifter: directed vectors, hold/reset sequences and random
// operations checked against an arithmetic reference model.
module tb_barrel_shifter;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] in;
  logic [31:0] shamt;
  logic        dir;
  logic        aorl;
  logic        in_valid;
  logic [31:0] out;
  logic        out_valid;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] s;
    logic        d;
    logic        ar;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[16];

  always #5 clk = ~clk;

  barrel_shifter #(
    .DATA_W  (32),
    .SHAMT_W (32)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in        (in),
    .shamt     (shamt),
    .dir       (dir),
    .aorl      (aorl),
    .in_valid  (in_valid),
    .out       (out),
    .out_valid (out_valid)
  );

  // Reference: shifts expressed as multiplication / floor division by 2**s.
  function automatic logic [31:0] ref_shift(input logic [31:0] a, input logic [31:0] s,
                                            input logic d, input logic ar);
    longint unsigned ua;
    longint          sa;
    longint          p;
    if (s >= 32) begin
      if (d == 1'b0 && ar == 1'b1 && a[31]) return 32'hFFFFFFFF;
      return 32'h0;
    end
    p  = longint'(1) << s;
    ua = longint'(a);
    if (d) return 32'((ua * longint'(p)) & 64'hFFFFFFFF);
    if (!ar) return 32'(ua / longint'(p));
    sa = longint'($signed(a));
    if (sa < 0) return 32'((sa - (p - 1)) / p);
    return 32'(sa / p);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input string name);
    @(negedge clk);
    in       = v.a;
    shamt    = v.s;
    dir      = v.d;
    aorl     = v.ar;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    check({name, "_out"}, out, v.exp);
    check({name, "_vld"}, {31'b0, out_valid}, 32'd1);
  endtask

  initial begin
    logic [31:0] held;
    logic [31:0] exp_out;
    logic        v;
    vec_t        rv;

    tbl[0]  = '{32'd4567,     32'd4,          1'b1, 1'b0, 32'h00011D70};
    tbl[1]  = '{32'd4567,     32'd4,          1'b0, 1'b0, 32'h0000011D};
    tbl[2]  = '{32'd4567,     32'd4,          1'b0, 1'b1, 32'h0000011D};
    tbl[3]  = '{32'hFFFFFFC0, 32'd4,          1'b1, 1'b0, 32'hFFFFFC00};
    tbl[4]  = '{32'hFFFFFFC0, 32'd4,          1'b0, 1'b0, 32'h0FFFFFFC};
    tbl[5]  = '{32'hFFFFFFC0, 32'd4,          1'b0, 1'b1, 32'hFFFFFFFC};
    tbl[6]  = '{32'hFFFFFFC0, 32'd0,          1'b1, 1'b0, 32'hFFFFFFC0};
    tbl[7]  = '{32'hFFFFFFC0, 32'd0,          1'b0, 1'b1, 32'hFFFFFFC0};
    tbl[8]  = '{32'hFFFFFFC0, 32'd31,         1'b0, 1'b1, 32'hFFFFFFFF};
    tbl[9]  = '{32'hFFFFFFC0, 32'd31,         1'b1, 1'b0, 32'h00000000};
    tbl[10] = '{32'hFFFFFFC0, 32'd40,         1'b0, 1'b1, 32'hFFFFFFFF};
    tbl[11] = '{32'hFFFFFFC0, 32'd40,         1'b0, 1'b0, 32'h00000000};
    tbl[12] = '{32'hFFFFFFC0, 32'h80000004,   1'b0, 1'b0, 32'h00000000};
    tbl[13] = '{32'hFFFFFFC0, 32'd32,         1'b1, 1'b1, 32'h00000000};
    tbl[14] = '{32'h80000000, 32'd31,         1'b0, 1'b0, 32'h00000001};
    tbl[15] = '{32'hFFFFFFC0, 32'd31,         1'b0, 1'b0, 32'h00000001};

    rst = 1'b1; in = '0; shamt = '0; dir = 1'b0; aorl = 1'b0; in_valid = 1'b0;
    #2;
    check("reset_out", out, 32'h0);
    check("reset_vld", {31'b0, out_valid}, 32'd0);

    // in_valid during reset must be ignored
    @(negedge clk);
    in = 32'h12345678; shamt = 32'd3; dir = 1'b1; in_valid = 1'b1;
    @(posedge clk);
    #1;
    check("rst_ignore_out", out, 32'h0);
    check("rst_ignore_vld", {31'b0, out_valid}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;

    for (int i = 0; i < 16; i++) run_vec(tbl[i], $sformatf("tbl%0d", i));

    // Hold: inputs toggle without in_valid
    held = tbl[15].exp;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in = $urandom; shamt = $urandom_range(0, 31); dir = ~dir; aorl = ~aorl;
      in_valid = 1'b0;
      @(posedge clk);
      #1;
      check($sformatf("hold%0d_out", i), out, held);
      check($sformatf("hold%0d_vld", i), {31'b0, out_valid}, 32'd0);
    end

    // Random back-to-back traffic with gaps
    exp_out = held;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      in    = $urandom;
      shamt = ($urandom_range(0, 7) == 0) ? $urandom : $urandom_range(0, 40);
      dir   = 1'($urandom_range(0, 1));
      aorl  = 1'($urandom_range(0, 1));
      v     = ($urandom_range(0, 3) != 0);
      in_valid = v;
      if (v) exp_out = ref_shift(in, shamt, dir, aorl);
      @(posedge clk);
      #1;
      check($sformatf("rnd%0d_out", i), out, exp_out);
      check($sformatf("rnd%0d_vld", i), {31'b0, out_valid}, {31'b0, v});
    end

    // Reset asserted between edges clears immediately
    run_vec(tbl[3], "pre_rst");
    #2;
    rst = 1'b1;
    #1;
    check("midrst_out", out, 32'h0);
    check("midrst_vld", {31'b0, out_valid}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    check("post_rst_out", out, 32'h0);
    check("post_rst_vld", {31'b0, out_valid}, 32'd0);

    rv = '{32'hFFFFFFC0, 32'd8, 1'b0, 1'b1, 32'hFFFFFFFF};
    run_vec(rv, "after_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
